// File: rtl/serv_wb_mem_resp.sv
// Wishbone data-bus memory responder with byte-lane writes and programmable wait states.
// Optional SERV_WB_MEM_ERR_EN: out-of-range addresses answer with o_wb_err instead of aliasing.
module serv_wb_mem_resp #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WAIT  = 0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack
`ifdef SERV_WB_MEM_ERR_EN
   ,
   output logic        o_wb_err
`endif
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned WW    = AW - 2;
   localparam int unsigned WORDS = DEPTH / 4;
   localparam int unsigned CW    = 4;
   localparam int unsigned DW    = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_ACK     = 2'd2,
      S_RECOVER = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   rdt_q, rdt_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic            access_c;
   logic            oor_c;
   logic            wr_en_c;
   logic [WW-1:0]   word_c;
   logic            unused_c;

   logic [DW-1:0]   mem_q [WORDS];

   assign word_c = i_wb_adr[AW-1:2];

   // Out-of-range detection only matters when the error response is built in
`ifdef SERV_WB_MEM_ERR_EN
   assign oor_c    = |i_wb_adr[31:AW];
   assign unused_c = ^i_wb_adr[1:0];
`else
   assign oor_c    = 1'b0;
   assign unused_c = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};
`endif

   // Next-state, access strobe and response generation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      access_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_wb_cyc) begin
               if (WAIT == 0) begin
                  access_c = 1'b1;
                  state_d  = S_ACK;
               end else begin
                  cnt_d   = CW'(WAIT - 1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               access_c = 1'b1;
               state_d  = S_ACK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_ACK:     state_d = S_RECOVER;
         S_RECOVER: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      ack_d = access_c & ~oor_c;
      err_d = access_c & oor_c;

      rdt_d = rdt_q;
      if (access_c && !i_wb_we) begin
         rdt_d = oor_c ? '0 : mem_q[word_c];
      end
   end

   // Memory is written only by a live access; a reset on the same edge suppresses it
   assign wr_en_c = access_c & i_wb_we & ~oor_c & ~i_rst;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdt_q   <= rdt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge i_clk) begin
      if (wr_en_c) begin
         for (int n = 0; n < 4; n++) begin
            if (i_wb_sel[n]) begin
               mem_q[word_c][8*n +: 8] <= i_wb_dat[8*n +: 8];
            end
         end
      end
   end

   assign o_wb_rdt = rdt_q;
   assign o_wb_ack = ack_q;
`ifdef SERV_WB_MEM_ERR_EN
   assign o_wb_err = err_q;
`endif

endmodule
